muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
- Iterative multi-cycle multiply/divide sequencer that owns the architectural HI/LO registers for MULT, MULTU, DIV, DIVU, MFHI and MFLO.
- Sits beside the execute ALU and is driven by decode/execute control.
- Raises a stall request whenever the pipeline issues a HI/LO read or a new mul/div operation while a previous operation is still in flight.

Parameters:
WIDTH, 32, operand width and HI/LO register width.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  issue a mul/div op this cycle
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
rs  input  WIDTH  operand A / dividend
rt  input  WIDTH  operand B / divisor
mf_req  input  1  MFHI/MFLO read request
mf_sel  input  1  0 selects HI, 1 selects LO
mf_data  output  WIDTH  selected HI/LO value (combinational mux)
busy  output  1  operation in flight
stall  output  1  hold the pipeline front end
done  output  1  one-cycle completion pulse
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Clock is clock; reset is synchronous and active-high.
- Reset values: state IDLE, busy 0, done 0, hi 0, lo 0, counter 0, internal accumulators 0.
- FSM states: IDLE, MUL, DIV, FIN.
- IDLE with start=1 at edge E0:
  - latch operand magnitudes (see Optional Feature) and the sign flags;
  - counter = WIDTH-1;
  - go to MUL if op[1]=0, otherwise DIV;
  - busy=1 from E0.
- MUL: one shift-add step per cycle on a 2*WIDTH product register, multiplier LSB-first.
- DIV: one restoring step per cycle on a {remainder, quotient} register pair:
  - shift left;
  - trial-subtract the divisor from the remainder;
  - set the quotient bit if the result is non-negative.
- Counter decrements each step. The step taken at counter==0 (edge E32 for WIDTH=32) moves the FSM to FIN.
- FIN, edge E33:
  - apply sign correction;
  - MUL results: hi = product[2W-1:W], lo = product[W-1:0];
  - DIV results: lo = quotient, hi = remainder;
  - state returns to IDLE, busy=0, and done=1 for exactly the following cycle.
- Latency: start sampled at E0, hi/lo and done visible after E33, i.e. 33 cycles busy for WIDTH=32.
- Divide by zero (rt=0, sampled at E0): no exception; final hi = original rs, lo = all ones; full latency is still taken.
- start while busy=1: the request is not accepted and operands are not latched; stall=1 for that cycle. The requester must hold start and operands until stall=0.
- stall = busy & (mf_req | start).
- mf_data = mf_sel ? lo : hi at all times; it is only architecturally valid while stall=0.
- start and mf_req together in IDLE: mf_data returns the old HI/LO value and the new op starts. The read is ordered before the op.
- hi and lo change only at the FIN edge or on reset; they hold through all other cycles.
- reset asserted mid-operation: FSM returns to IDLE on that edge, hi/lo cleared, no done pulse.

Optional Feature:
- Macro: MULDIV_SIGNED_EN.
- Defined:
  - MULT and DIV take operand absolute values;
  - the product is negated iff the operand signs differ;
  - the quotient is negated iff the signs differ;
  - the remainder takes the sign of the dividend.
  - -2^31 / -1 yields lo=0x80000000, hi=0.
  - Divide by zero behaves as in Behaviour; hi = original signed rs.
- Undefined: no sign logic is synthesised; MULT behaves as MULTU and DIV behaves as DIVU.

Test Plan:
- MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF, start at E0 -> busy for 33 cycles, done pulse after E33, hi=0xFFFFFFFE, lo=0x00000001.
- DIVU rs=100 rt=7 -> lo=14, hi=2; a subsequent MFLO (mf_req=1, mf_sel=1) returns mf_data=14 with stall=0.
- DIVU rs=0x1234 rt=0 -> after 33 cycles hi=0x00001234, lo=0xFFFFFFFF, done pulses once.
- MULT rs=0xFFFFFFFD (-3) rt=5 -> with MULTDIV_SIGNED_EN: hi=0xFFFFFFFF, lo=0xFFFFFFF1; without it: hi=0x00000004, lo=0xFFFFFFF1.
- DIV rs=-7 rt=2 with MULDIV_SIGNED_EN -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also -2^31 / -1 -> lo=0x80000000, hi=0.
- MULTU 6*7 started, then mf_req=1 at cycle 5 -> stall=1 until busy drops, then mf_data=lo=42. Separately, reset pulsed at cycle 10 of a DIVU -> busy=0, hi=lo=0, no done pulse.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative multiply/divide sequencer owning the HI/LO registers.
// MULT/MULTU use shift-add, one step per cycle, multiplier consumed LSB-first.
// DIV/DIVU use restoring division, one step per cycle.
// Optional feature macro: MULDIV_SIGNED_EN. When it is defined, MULT/DIV are
// signed operations. When it is undefined, they behave as MULTU/DIVU.
module muldiv_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             mf_req,
  input  logic             mf_sel,
  output logic [WIDTH-1:0] mf_data,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  // The multiply uses {partial product, remaining multiplier}.
  // The divide uses {remainder, quotient}.
  logic [2*WIDTH-1:0]  acc_q, acc_d;
  // opb holds the multiplicand or the divisor magnitude.
  logic [WIDTH-1:0]    opb_q, opb_d;
  logic                is_div_q, is_div_d;
  logic [WIDTH-1:0]    hi_q, hi_d;
  logic [WIDTH-1:0]    lo_q, lo_d;
  logic                done_q, done_d;

  logic [WIDTH-1:0]    a_mag;
  logic [WIDTH-1:0]    b_mag;

  // Datapath step signals
  logic [WIDTH:0]      mul_sum;
  logic [2*WIDTH-1:0]  mul_next;
  logic [WIDTH:0]      rem_sh;
  logic                div_ge;
  logic [WIDTH-1:0]    div_rem;
  logic [2*WIDTH-1:0]  div_next;

`ifdef MULDIV_SIGNED_EN
  logic neg_res_q, neg_res_d;
  logic neg_rem_q, neg_rem_d;
  logic dz_q, dz_d;
  logic a_neg, b_neg;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return ~x + 1'b1;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return ~x + 1'b1;
  endfunction

  // MULT and DIV (op[0]=0) work on magnitudes. The result signs are recorded here.
  always_comb begin
    a_neg = ~op[0] & rs[WIDTH-1];
    b_neg = ~op[0] & rt[WIDTH-1];
    a_mag = a_neg ? neg_w(rs) : rs;
    b_mag = b_neg ? neg_w(rt) : rt;
  end
`else
  logic unused_op0;
  assign unused_op0 = op[0];
  assign a_mag      = rs;
  assign b_mag      = rt;
`endif

  // Multiply step: add the multiplicand on a set LSB, then shift right.
  // Divide step: shift left, then do a trial subtract on a WIDTH+1-bit remainder.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (opb_q & {WIDTH{acc_q[0]}})};
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    div_ge   = (rem_sh >= {1'b0, opb_q});
    div_rem  = div_ge ? (rem_sh[WIDTH-1:0] - opb_q) : rem_sh[WIDTH-1:0];
    div_next = {div_rem, acc_q[WIDTH-2:0], div_ge};
  end

  // Next-state logic: sequencer FSM, iteration stepping, and the final HI/LO write
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
`ifdef MULDIV_SIGNED_EN
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d    = {{WIDTH{1'b0}}, a_mag};
          opb_d    = b_mag;
          cnt_d    = CNT_W'(WIDTH - 1);
          is_div_d = op[1];
          state_d  = op[1] ? DIV : MUL;
`ifdef MULDIV_SIGNED_EN
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          dz_d      = (rt == '0);
`endif
        end
      end
      MUL, DIV: begin
        acc_d = (state_q == DIV) ? div_next : mul_next;
        if (cnt_q == '0) begin
          state_d = FIN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FIN: begin
        if (is_div_q) begin
          lo_d = acc_q[WIDTH-1:0];
          hi_d = acc_q[2*WIDTH-1:WIDTH];
`ifdef MULDIV_SIGNED_EN
          // A divide by zero keeps its all-ones quotient regardless of sign.
          if (neg_res_q && !dz_q) lo_d = neg_w(acc_q[WIDTH-1:0]);
          if (neg_rem_q)          hi_d = neg_w(acc_q[2*WIDTH-1:WIDTH]);
`endif
        end else begin
`ifdef MULDIV_SIGNED_EN
          {hi_d, lo_d} = neg_res_q ? neg_2w(acc_q) : acc_q;
`else
          {hi_d, lo_d} = acc_q;
`endif
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything, including the accumulators
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
`ifdef MULDIV_SIGNED_EN
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
`endif
    end
  end

  assign busy    = (state_q != IDLE);
  assign stall   = busy & (mf_req | start);
  assign mf_data = mf_sel ? lo_q : hi_q;
  assign done    = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed testbench for muldiv_ctrl. Expected values are computed by hand.
// Signed expectations are selected by MULDIV_SIGNED_EN.
module tb_muldiv_ctrl;

  logic        clock;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        mf_req;
  logic        mf_sel;
  logic [31:0] mf_data;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

`ifdef MULDIV_SIGNED_EN
  localparam logic [31:0] MULT_HI = 32'hFFFF_FFFF;
  localparam logic [31:0] DIV_LO  = 32'hFFFF_FFFD;
  localparam logic [31:0] DIV_HI  = 32'hFFFF_FFFF;
  localparam logic [31:0] MIN_LO  = 32'h8000_0000;
  localparam logic [31:0] MIN_HI  = 32'h0000_0000;
`else
  localparam logic [31:0] MULT_HI = 32'h0000_0004;
  localparam logic [31:0] DIV_LO  = 32'h7FFF_FFFC;
  localparam logic [31:0] DIV_HI  = 32'h0000_0001;
  localparam logic [31:0] MIN_LO  = 32'h0000_0000;
  localparam logic [31:0] MIN_HI  = 32'h8000_0000;
`endif

  muldiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs      (rs),
    .rt      (rt),
    .mf_req  (mf_req),
    .mf_sel  (mf_sel),
    .mf_data (mf_data),
    .busy    (busy),
    .stall   (stall),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present an op for one edge (E0), then drop start
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op    = o;
    rs    = a;
    rt    = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Full operation: latency, done pulse, results, and HI/LO holding while busy
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    int          cyc;
    logic        hold_bad;
    old_hi   = hi;
    old_lo   = lo;
    hold_bad = 1'b0;
    cyc      = 0;
    issue(o, a, b);
    check_val({tag, "_busy"}, 64'(busy), 64'd1);
    while (busy && cyc < 100) begin
      if (done || hi !== old_hi || lo !== old_lo) hold_bad = 1'b1;
      cyc++;
      tick();
    end
    check_val({tag, "_cycles"}, 64'(cyc), 64'd33);
    check_val({tag, "_hold"}, 64'(hold_bad), 64'd0);
    check_val({tag, "_done"}, 64'(done), 64'd1);
    check_val({tag, "_hi"}, 64'(hi), 64'(eh));
    check_val({tag, "_lo"}, 64'(lo), 64'(el));
    tick();
    check_val({tag, "_done_off"}, 64'(done), 64'd0);
  endtask

  initial begin
    int   cyc;
    logic bad;
    reset  = 1'b1;
    start  = 1'b0;
    op     = 2'b00;
    rs     = '0;
    rt     = '0;
    mf_req = 1'b0;
    mf_sel = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_hi", 64'(hi), 64'd0);
    check_val("rst_lo", 64'(lo), 64'd0);
    check_val("rst_stall", 64'(stall), 64'd0);

    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);

    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    mf_req = 1'b1;
    mf_sel = 1'b1;
    #1;
    check_val("mflo_data", 64'(mf_data), 64'd14);
    check_val("mflo_stall", 64'(stall), 64'd0);
    mf_sel = 1'b0;
    #1;
    check_val("mfhi_data", 64'(mf_data), 64'd2);
    mf_req = 1'b0;

    run_op("divu_dz", OP_DIVU, 32'h0000_1234, 32'h0, 32'h0000_1234, 32'hFFFF_FFFF);
    run_op("mult_m3_5", OP_MULT, 32'hFFFF_FFFD, 32'd5, MULT_HI, 32'hFFFF_FFF1);
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, DIV_HI, DIV_LO);
    run_op("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, MIN_HI, MIN_LO);

    // MFLO issued mid-operation must stall until the multiply retires
    issue(OP_MULTU, 32'd6, 32'd7);
    repeat (4) tick();
    mf_req = 1'b1;
    mf_sel = 1'b1;
    #1;
    bad = 1'b0;
    cyc = 0;
    while (busy && cyc < 100) begin
      if (stall !== 1'b1) bad = 1'b1;
      cyc++;
      tick();
    end
    check_val("mf_stall_busy", 64'(bad), 64'd0);
    check_val("mf_stall_cycles", 64'(cyc), 64'd29);
    check_val("mf_stall_off", 64'(stall), 64'd0);
    check_val("mf_data_42", 64'(mf_data), 64'd42);
    mf_req = 1'b0;
    tick();

    // A start held while busy is refused until the unit is idle, then accepted
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (3) tick();
    op    = OP_MULTU;
    rs    = 32'd2;
    rt    = 32'd3;
    start = 1'b1;
    #1;
    bad = 1'b0;
    cyc = 0;
    while (busy && cyc < 100) begin
      if (stall !== 1'b1) bad = 1'b1;
      cyc++;
      tick();
    end
    check_val("sb_stall", 64'(bad), 64'd0);
    check_val("sb_first_lo", 64'(lo), 64'd14);
    check_val("sb_first_hi", 64'(hi), 64'd2);
    check_val("sb_stall_off", 64'(stall), 64'd0);
    tick();
    start = 1'b0;
    check_val("sb_accept", 64'(busy), 64'd1);
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      tick();
    end
    check_val("sb_second_lo", 64'(lo), 64'd6);
    check_val("sb_second_hi", 64'(hi), 64'd0);
    tick();

    // A read and a start together in IDLE: the read sees the old LO, and the op starts
    op     = OP_MULTU;
    rs     = 32'd5;
    rt     = 32'd5;
    start  = 1'b1;
    mf_req = 1'b1;
    mf_sel = 1'b1;
    #1;
    check_val("rd_first_data", 64'(mf_data), 64'd6);
    check_val("rd_first_stall", 64'(stall), 64'd0);
    tick();
    start  = 1'b0;
    mf_req = 1'b0;
    check_val("rd_first_busy", 64'(busy), 64'd1);
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      tick();
    end
    check_val("rd_first_lo", 64'(lo), 64'd25);
    tick();

    // A reset in the middle of a divide aborts it without a done pulse
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_val("mid_rst_busy", 64'(busy), 64'd0);
    check_val("mid_rst_hi", 64'(hi), 64'd0);
    check_val("mid_rst_lo", 64'(lo), 64'd0);
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
      tick();
    end
    check_val("mid_rst_no_done", 64'(bad), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
